// File: rtl/parallel2serial_if.sv
// parallel2serial_if: word handshake into the serializer and the framed serial link out of it
interface parallel2serial_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] din_parallel;
  logic din_valid, din_ready, dout_serial, dout_valid, busy;
  modport master(output din_parallel, din_valid, input din_ready, dout_serial, dout_valid, busy);
  modport slave(input din_parallel, din_valid, output din_ready, dout_serial, dout_valid, busy);
endinterface

// File: rtl/parallel2serial.sv
// parallel2serial: buffered word-to-MSB-first serial framer with idle gap; P2S_FIFO_EN selects FIFO buffer over single holding register
module parallel2serial #(
  parameter int DATA_W = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int GAP_CYCLES = 1
) (
  input logic clk,
  input logic rst_n,
  parallel2serial_if.slave bus
);
  localparam int CW = $clog2(DATA_W);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
  state_t state, state_nx;
  logic [DATA_W-1:0] sh, sh_nx, head;
  logic [CW-1:0] cnt, cnt_nx;
  logic [GW-1:0] gcnt, gcnt_nx;
  logic vld, vld_nx, ready, busy_r, empty, empty_nx, full_nx, push, pop;
  if (GAP_CYCLES < 1 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("parallel2serial: GAP_CYCLES must be >= 1 and FIFO_DEPTH a power of two >= 2");
  end
  assign push = bus.din_valid & ready;
`ifdef P2S_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp, wp_nx, rp_nx;
  assign wp_nx = wp + {{AW{1'b0}}, push};
  assign rp_nx = rp + {{AW{1'b0}}, pop};
  assign empty = wp == rp;
  assign empty_nx = wp_nx == rp_nx;
  assign full_nx = (wp_nx[AW] != rp_nx[AW]) && (wp_nx[AW-1:0] == rp_nx[AW-1:0]);
  assign head = mem[rp[AW-1:0]];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
    end else begin
      wp <= wp_nx;
      rp <= rp_nx;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wp[AW-1:0]] <= bus.din_parallel;
  end
`else
  logic [DATA_W-1:0] hold;
  logic hold_v, hold_v_nx;
  assign hold_v_nx = push | (hold_v & ~pop);
  assign empty = ~hold_v;
  assign empty_nx = ~hold_v_nx;
  assign full_nx = hold_v_nx;
  assign head = hold;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hold_v <= 1'b0;
    else hold_v <= hold_v_nx;
  end
  always_ff @(posedge clk) begin
    if (push) hold <= bus.din_parallel;
  end
`endif
  // A finished gap loads straight into SHIFT so back-to-back frames are exactly GAP_CYCLES apart
  always_comb begin
    state_nx = state;
    sh_nx = sh;
    cnt_nx = cnt;
    gcnt_nx = gcnt;
    vld_nx = vld;
    pop = 1'b0;
    case (state)
      IDLE: pop = ~empty;
      SHIFT: begin
        sh_nx = sh << 1;
        cnt_nx = cnt + 1'b1;
        if (cnt == CW'(DATA_W - 1)) begin
          state_nx = GAP;
          vld_nx = 1'b0;
          gcnt_nx = '0;
        end
      end
      GAP: begin
        gcnt_nx = gcnt + 1'b1;
        if (gcnt == GW'(GAP_CYCLES - 1)) begin
          state_nx = IDLE;
          pop = ~empty;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (pop) begin
      state_nx = SHIFT;
      sh_nx = head;
      cnt_nx = '0;
      vld_nx = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      sh <= '0;
      cnt <= '0;
      gcnt <= '0;
      vld <= 1'b0;
      ready <= 1'b1;
      busy_r <= 1'b0;
    end else begin
      state <= state_nx;
      sh <= sh_nx;
      cnt <= cnt_nx;
      gcnt <= gcnt_nx;
      vld <= vld_nx;
      ready <= ~full_nx;
      busy_r <= (state_nx != IDLE) | ~empty_nx;
    end
  end
  assign bus.din_ready = ready;
  assign bus.dout_valid = vld;
  assign bus.dout_serial = vld & sh[DATA_W-1];
  assign bus.busy = busy_r;
endmodule

// File: tb/tb_parallel2serial.sv
// tb_parallel2serial: directed checks of framing, handshake, buffering, reset abort and gap length
module tb_parallel2serial;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  parallel2serial_if #(.DATA_W(8)) a();
  parallel2serial_if #(.DATA_W(8)) b();
  parallel2serial #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(1)) u_dut (.clk(clk), .rst_n(rst_n), .bus(a));
  parallel2serial #(.DATA_W(8), .FIFO_DEPTH(4), .GAP_CYCLES(3)) u_gap (.clk(clk), .rst_n(rst_n), .bus(b));

  // deserializer models: bit counters restart whenever dout_valid drops
  logic [7:0] words[$];
  int lens[$];
  int gaps[$];
  logic [7:0] sr = '0;
  int run = 0, idle = 0, leak = 0;
  always @(negedge clk) begin
    if (!rst_n) begin
      run = 0;
      idle = 0;
      sr = '0;
    end else if (a.dout_valid) begin
      if (run == 0) gaps.push_back(idle);
      sr = {sr[6:0], a.dout_serial};
      run++;
      idle = 0;
    end else begin
      if (run != 0) begin
        lens.push_back(run);
        words.push_back(sr);
      end
      if (a.dout_serial !== 1'b0) leak++;
      run = 0;
      idle++;
    end
  end

  logic [7:0] bwords[$];
  int blens[$];
  int bgaps[$];
  int brise[$];
  logic [7:0] bsr = '0;
  int brun = 0, bidle = 0, cyc = 0;
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      brun = 0;
      bidle = 0;
    end else if (b.dout_valid) begin
      if (brun == 0) begin
        bgaps.push_back(bidle);
        brise.push_back(cyc);
      end
      bsr = {bsr[6:0], b.dout_serial};
      brun++;
      bidle = 0;
    end else begin
      if (brun != 0) begin
        blens.push_back(brun);
        bwords.push_back(bsr);
      end
      brun = 0;
      bidle++;
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1, "timeout");
  end

  task automatic test_reset();
    a.din_valid = 1'b0;
    a.din_parallel = '0;
    b.din_valid = 1'b0;
    b.din_parallel = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (a.dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a.dout_valid); end
    checks++; if (a.dout_serial !== 1'b0) begin errors++; $display("FAIL reset_serial got %b want 0", a.dout_serial); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a.busy); end
    checks++; if (a.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b want 1", a.din_ready); end
    checks++; if (b.din_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_gap got %b want 1", b.din_ready); end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", a.busy); end
    checks++; if (a.dout_valid !== 1'b0) begin errors++; $display("FAIL idle_valid got %b want 0", a.dout_valid); end
  endtask

  task automatic test_single();
    logic [7:0] pat = 8'b10100101;
    logic exp_rdy;
`ifdef P2S_FIFO_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    words.delete(); lens.delete(); gaps.delete();
    @(negedge clk);
    a.din_parallel = 8'hA5;
    a.din_valid = 1'b1;
    @(negedge clk);
    a.din_valid = 1'b0;
    checks++; if (a.dout_valid !== 1'b0) begin errors++; $display("FAIL single_latency valid got %b want 0", a.dout_valid); end
    checks++; if (a.busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", a.busy); end
    checks++; if (a.din_ready !== exp_rdy) begin errors++; $display("FAIL single_ready got %b want %b", a.din_ready, exp_rdy); end
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++; if (a.dout_valid !== 1'b1) begin errors++; $display("FAIL single_valid bit %0d got %b want 1", i, a.dout_valid); end
      checks++; if (a.dout_serial !== pat[7-i]) begin errors++; $display("FAIL single_bit %0d got %b want %b", i, a.dout_serial, pat[7-i]); end
    end
    @(negedge clk);
    checks++; if (a.dout_valid !== 1'b0) begin errors++; $display("FAIL single_end valid got %b want 0", a.dout_valid); end
    checks++; if (a.dout_serial !== 1'b0) begin errors++; $display("FAIL single_end serial got %b want 0", a.dout_serial); end
    repeat (3) @(negedge clk);
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL single_done busy got %b want 0", a.busy); end
    checks++; if (words.size() != 1) begin errors++; $display("FAIL single_count got %0d want 1", words.size()); end
    else begin
      checks++; if (words[0] !== 8'hA5) begin errors++; $display("FAIL single_word got %h want a5", words[0]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] w [4] = '{8'h00, 8'hFF, 8'h3C, 8'h81};
    int k = 0;
    logic xfer;
    repeat (4) @(negedge clk);
    words.delete(); lens.delete(); gaps.delete(); leak = 0;
    a.din_parallel = w[0];
    a.din_valid = 1'b1;
    for (int c = 0; c < 100 && k < 4; c++) begin
      xfer = a.din_ready;
      @(negedge clk);
      if (xfer) begin
        k++;
        if (k < 4) a.din_parallel = w[k];
        else a.din_valid = 1'b0;
      end
    end
    for (int c = 0; c < 100 && words.size() < 4; c++) @(negedge clk);
    checks++; if (words.size() != 4) begin errors++; $display("FAIL b2b_count got %0d want 4", words.size()); end
    for (int i = 0; i < 4; i++) if (i < words.size()) begin
      checks++; if (words[i] !== w[i]) begin errors++; $display("FAIL b2b_word %0d got %h want %h", i, words[i], w[i]); end
      checks++; if (lens[i] != 8) begin errors++; $display("FAIL b2b_len %0d got %0d want 8", i, lens[i]); end
    end
    for (int i = 1; i < 4; i++) if (i < gaps.size()) begin
      checks++; if (gaps[i] != 1) begin errors++; $display("FAIL b2b_gap %0d got %0d want 1", i, gaps[i]); end
    end
    checks++; if (leak != 0) begin errors++; $display("FAIL idle_serial_zero got %0d want 0", leak); end
  endtask

`ifdef P2S_FIFO_EN
  task automatic test_fifo_stall();
    logic [7:0] w [6] = '{8'h5A, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    int k = 1, held = 0;
    logic xfer;
    repeat (4) @(negedge clk);
    words.delete(); lens.delete(); gaps.delete();
    a.din_parallel = w[0];
    a.din_valid = 1'b1;
    @(negedge clk);
    a.din_valid = 1'b0;
    for (int c = 0; c < 10 && a.dout_valid !== 1'b1; c++) @(negedge clk);
    a.din_parallel = w[1];
    a.din_valid = 1'b1;
    for (int c = 0; c < 100 && k < 6; c++) begin
      xfer = a.din_ready;
      if (k == 5 && !xfer) held++;
      @(negedge clk);
      if (xfer) begin
        k++;
        if (k == 5) begin
          checks++; if (a.din_ready !== 1'b0) begin errors++; $display("FAIL fifo_full_ready got %b want 0", a.din_ready); end
        end
        if (k < 6) a.din_parallel = w[k];
        else a.din_valid = 1'b0;
      end
    end
    checks++; if (held != 5) begin errors++; $display("FAIL fifo_held_cycles got %0d want 5", held); end
    for (int c = 0; c < 200 && words.size() < 6; c++) @(negedge clk);
    checks++; if (words.size() != 6) begin errors++; $display("FAIL fifo_count got %0d want 6", words.size()); end
    for (int i = 0; i < 6; i++) if (i < words.size()) begin
      checks++; if (words[i] !== w[i]) begin errors++; $display("FAIL fifo_word %0d got %h want %h", i, words[i], w[i]); end
    end
  endtask
`else
  task automatic test_hold();
    int low = 0;
    repeat (4) @(negedge clk);
    words.delete(); lens.delete(); gaps.delete();
    a.din_parallel = 8'h12;
    a.din_valid = 1'b1;
    @(negedge clk);
    a.din_parallel = 8'h34;
    checks++; if (a.din_ready !== 1'b0) begin errors++; $display("FAIL hold_full_ready got %b want 0", a.din_ready); end
    for (int c = 0; c < 10 && a.din_ready !== 1'b1; c++) @(negedge clk);
    @(negedge clk);
    a.din_valid = 1'b0;
    checks++; if (a.dout_valid !== 1'b1) begin errors++; $display("FAIL hold_xfer_in_shift valid got %b want 1", a.dout_valid); end
    for (int c = 0; c < 40 && a.din_ready === 1'b0; c++) begin
      low++;
      @(negedge clk);
    end
    checks++; if (low != 8) begin errors++; $display("FAIL hold_ready_low got %0d want 8", low); end
    checks++; if (a.dout_valid !== 1'b1) begin errors++; $display("FAIL hold_reload valid got %b want 1", a.dout_valid); end
    checks++; if (a.dout_serial !== 1'b0) begin errors++; $display("FAIL hold_reload msb got %b want 0", a.dout_serial); end
    for (int c = 0; c < 40 && words.size() < 2; c++) @(negedge clk);
    checks++; if (words.size() != 2) begin errors++; $display("FAIL hold_count got %0d want 2", words.size()); end
    else begin
      checks++; if (words[0] !== 8'h12) begin errors++; $display("FAIL hold_word0 got %h want 12", words[0]); end
      checks++; if (words[1] !== 8'h34) begin errors++; $display("FAIL hold_word1 got %h want 34", words[1]); end
    end
  endtask
`endif

  task automatic test_reset_mid();
    int n = 1;
    logic xfer;
    repeat (4) @(negedge clk);
    a.din_parallel = 8'hC3;
    a.din_valid = 1'b1;
    @(negedge clk);
    a.din_parallel = 8'h11;
    for (int c = 0; c < 4; c++) begin
      xfer = a.din_ready & a.din_valid;
      @(negedge clk);
      if (xfer) begin
        n++;
        if (n == 2) a.din_parallel = 8'h22;
        else a.din_valid = 1'b0;
      end
    end
    a.din_valid = 1'b0;
    checks++; if (a.dout_valid !== 1'b1) begin errors++; $display("FAIL mid_frame valid got %b want 1", a.dout_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (a.dout_valid !== 1'b0) begin errors++; $display("FAIL abort_valid got %b want 0", a.dout_valid); end
    checks++; if (a.dout_serial !== 1'b0) begin errors++; $display("FAIL abort_serial got %b want 0", a.dout_serial); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", a.busy); end
    checks++; if (a.din_ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b want 1", a.din_ready); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    words.delete(); lens.delete(); gaps.delete();
    repeat (20) @(negedge clk);
    checks++; if (words.size() != 0) begin errors++; $display("FAIL abort_flushed got %0d words want 0", words.size()); end
    checks++; if (a.busy !== 1'b0) begin errors++; $display("FAIL abort_idle busy got %b want 0", a.busy); end
    a.din_parallel = 8'h5A;
    a.din_valid = 1'b1;
    @(negedge clk);
    a.din_valid = 1'b0;
    for (int c = 0; c < 30 && words.size() < 1; c++) @(negedge clk);
    checks++; if (words.size() != 1) begin errors++; $display("FAIL post_reset_count got %0d want 1", words.size()); end
    else begin
      checks++; if (words[0] !== 8'h5A) begin errors++; $display("FAIL post_reset_word got %h want 5a", words[0]); end
      checks++; if (lens[0] != 8) begin errors++; $display("FAIL post_reset_len got %0d want 8", lens[0]); end
    end
  endtask

  task automatic test_gap3();
    int k = 0;
    logic xfer;
    repeat (4) @(negedge clk);
    bwords.delete(); blens.delete(); bgaps.delete(); brise.delete();
    b.din_parallel = 8'h55;
    b.din_valid = 1'b1;
    for (int c = 0; c < 100 && k < 2; c++) begin
      xfer = b.din_ready;
      @(negedge clk);
      if (xfer) begin
        k++;
        if (k < 2) b.din_parallel = 8'hAA;
        else b.din_valid = 1'b0;
      end
    end
    for (int c = 0; c < 60 && bwords.size() < 2; c++) @(negedge clk);
    checks++; if (bwords.size() != 2) begin errors++; $display("FAIL gap3_count got %0d want 2", bwords.size()); end
    else begin
      checks++; if (bwords[0] !== 8'h55) begin errors++; $display("FAIL gap3_word0 got %h want 55", bwords[0]); end
      checks++; if (bwords[1] !== 8'hAA) begin errors++; $display("FAIL gap3_word1 got %h want aa", bwords[1]); end
      checks++; if (blens[0] != 8 || blens[1] != 8) begin errors++; $display("FAIL gap3_len got %0d,%0d want 8,8", blens[0], blens[1]); end
      checks++; if (bgaps[1] != 3) begin errors++; $display("FAIL gap3_idle got %0d want 3", bgaps[1]); end
      checks++; if (brise[1] - brise[0] != 11) begin errors++; $display("FAIL gap3_period got %0d want 11", brise[1] - brise[0]); end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
`ifdef P2S_FIFO_EN
    test_fifo_stall();
`else
    test_hold();
`endif
    test_reset_mid();
    test_gap3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
